// File: rtl/clk_time_set_ctrl.sv
// Sequencer that range-checks an hh:mm:ss set request and writes it into the
// real-clock core as three load strobes (hours, minutes, seconds) under hold.
module clk_time_set_ctrl #(
    parameter int DW       = 6,
    parameter int LOAD_GAP = 2,
    parameter int HR_MAX   = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_req,
    input  logic [DW-1:0] set_hh,
    input  logic [DW-1:0] set_mm,
    input  logic [DW-1:0] set_ss,
    output logic          set_ack,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          hold,
    output logic          load,
    output logic [1:0]    addrs,
    output logic [DW-1:0] data_out
);

    localparam int            MS_MAX = 59;
    localparam logic [DW-1:0] HR_LIM = HR_MAX[DW-1:0];
    localparam logic [DW-1:0] MS_LIM = MS_MAX[DW-1:0];
    localparam logic [3:0]    GAP_V  = LOAD_GAP[3:0];

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_ERR,
        S_WR_HR,
        S_GAP1,
        S_WR_MIN,
        S_GAP2,
        S_WR_SEC,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hh_q    <= '0;
            mm_q    <= '0;
            ss_q    <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        set_ack = 1'b0;
        err     = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (set_req) begin
                    hh_d    = set_hh;
                    mm_d    = set_mm;
                    ss_d    = set_ss;
                    set_ack = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (hh_q <= HR_LIM && mm_q <= MS_LIM && ss_q <= MS_LIM)
                    state_d = S_WR_HR;
                else
                    state_d = S_ERR;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            S_WR_HR: begin
                load   = 1'b1;
                addr_d = 2'b10;
                data_d = hh_q;
                if (LOAD_GAP == 0) begin
                    state_d = S_WR_MIN;
                end else begin
                    state_d = S_GAP1;
                    cnt_d   = GAP_V;
                end
            end
            S_GAP1: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_WR_MIN;
            end
            S_WR_MIN: begin
                load   = 1'b1;
                addr_d = 2'b01;
                data_d = mm_q;
                if (LOAD_GAP == 0) begin
                    state_d = S_WR_SEC;
                end else begin
                    state_d = S_GAP2;
                    cnt_d   = GAP_V;
                end
            end
            S_GAP2: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_WR_SEC;
            end
            S_WR_SEC: begin
                load    = 1'b1;
                addr_d  = 2'b00;
                data_d  = ss_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus shows the new value during a write and the last written value otherwise.
    assign addrs    = addr_d;
    assign data_out = data_d;
    assign busy     = (state_q != S_IDLE);
    assign hold     = (state_q != S_IDLE) && (state_q != S_CHECK) && (state_q != S_ERR);

endmodule

// File: tb/tb_clk_time_set_ctrl.sv
// Scoreboard bench: three instances (default, LOAD_GAP=0, HR_MAX=11) driven by
// directed requests; a negedge monitor pops expected pulse events and compares.
module tb_clk_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       set_req [3];
    logic [5:0] set_hh [3];
    logic [5:0] set_mm [3];
    logic [5:0] set_ss [3];
    logic       ack [3];
    logic       busy [3];
    logic       dn [3];
    logic       er [3];
    logic       hold [3];
    logic       ld [3];
    logic [1:0] addrs [3];
    logic [5:0] dout [3];

    always #5 clk = ~clk;

    clk_time_set_ctrl #(.DW(6), .LOAD_GAP(2), .HR_MAX(23)) u0 (
        .clk(clk), .reset(reset), .set_req(set_req[0]), .set_hh(set_hh[0]),
        .set_mm(set_mm[0]), .set_ss(set_ss[0]), .set_ack(ack[0]), .busy(busy[0]),
        .done(dn[0]), .err(er[0]), .hold(hold[0]), .load(ld[0]), .addrs(addrs[0]),
        .data_out(dout[0]));
    clk_time_set_ctrl #(.DW(6), .LOAD_GAP(0), .HR_MAX(23)) u1 (
        .clk(clk), .reset(reset), .set_req(set_req[1]), .set_hh(set_hh[1]),
        .set_mm(set_mm[1]), .set_ss(set_ss[1]), .set_ack(ack[1]), .busy(busy[1]),
        .done(dn[1]), .err(er[1]), .hold(hold[1]), .load(ld[1]), .addrs(addrs[1]),
        .data_out(dout[1]));
    clk_time_set_ctrl #(.DW(6), .LOAD_GAP(2), .HR_MAX(11)) u2 (
        .clk(clk), .reset(reset), .set_req(set_req[2]), .set_hh(set_hh[2]),
        .set_mm(set_mm[2]), .set_ss(set_ss[2]), .set_ack(ack[2]), .busy(busy[2]),
        .done(dn[2]), .err(er[2]), .hold(hold[2]), .load(ld[2]), .addrs(addrs[2]),
        .data_out(dout[2]));

    // pulses = {set_ack, load, done, err}
    typedef struct {
        int         inst;
        int         cyc;
        logic [3:0] pulses;
        logic [1:0] a;
        logic [5:0] d;
        bit         chk_ad;
        logic       hold;
        logic       busy;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  nld [3];
    int  nhold [3];
    int  gap [3];

    always @(posedge clk) cyc++;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(int i, int c, logic [3:0] p, logic [1:0] a, logic [5:0] d,
                                 bit chk_ad, logic h, logic b);
        ev_t e;
        e.inst = i; e.cyc = c; e.pulses = p; e.a = a; e.d = d;
        e.chk_ad = chk_ad; e.hold = h; e.busy = b;
        q.push_back(e);
    endfunction

    // Expected event list of one accepted request, hand-derived latencies.
    function automatic void push_seq(int i, int t0, logic [5:0] h, logic [5:0] m,
                                     logic [5:0] s, bit ok);
        int g;
        g = gap[i];
        push(i, t0, 4'b1000, 2'b00, 6'd0, 1'b0, 1'b0, 1'b0);
        if (ok) begin
            push(i, t0 + 2,         4'b0100, 2'b10, h, 1'b1, 1'b1, 1'b1);
            push(i, t0 + 3 + g,     4'b0100, 2'b01, m, 1'b1, 1'b1, 1'b1);
            push(i, t0 + 4 + 2 * g, 4'b0100, 2'b00, s, 1'b1, 1'b1, 1'b1);
            push(i, t0 + 5 + 2 * g, 4'b0010, 2'b00, 6'd0, 1'b0, 1'b1, 1'b1);
        end else begin
            push(i, t0 + 2, 4'b0001, 2'b00, 6'd0, 1'b0, 1'b0, 1'b1);
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ld[i]) nld[i]++;
            if (hold[i]) nhold[i]++;
            if (ack[i] || ld[i] || dn[i] || er[i]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: inst %0d cycle %0d pulses %b, none expected",
                             i, cyc, {ack[i], ld[i], dn[i], er[i]});
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.inst != i || e.cyc != cyc ||
                        e.pulses != {ack[i], ld[i], dn[i], er[i]} ||
                        e.hold != hold[i] || e.busy != busy[i] ||
                        (e.chk_ad && (e.a != addrs[i] || e.d != dout[i]))) begin
                        n_bad++;
                        $display("FAIL event: got inst %0d cyc %0d pulses %b a %b d %0d hold %b busy %b; expected inst %0d cyc %0d pulses %b a %b d %0d hold %b busy %b",
                                 i, cyc, {ack[i], ld[i], dn[i], er[i]}, addrs[i], dout[i],
                                 hold[i], busy[i], e.inst, e.cyc, e.pulses, e.a, e.d,
                                 e.hold, e.busy);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        #1;
    endtask

    task automatic check_zero(string name);
        for (int i = 0; i < 3; i++)
            chk(name, int'({ack[i], busy[i], dn[i], er[i], hold[i], ld[i], addrs[i], dout[i]}), 0);
    endtask

    // Issue a request on instance i, hold set_req for hcyc edges, wait for completion.
    task automatic req(int i, logic [5:0] h, logic [5:0] m, logic [5:0] s, bit ok,
                       int hcyc, output int t0);
        @(posedge clk); #1;
        t0 = cyc;
        set_hh[i] = h; set_mm[i] = m; set_ss[i] = s; set_req[i] = 1'b1;
        push_seq(i, t0, h, m, s, ok);
        repeat (hcyc) @(posedge clk);
        #1 set_req[i] = 1'b0;
        wait_cyc(t0 + 12);
    endtask

    initial begin
        int t0;
        int hb;
        gap[0] = 2; gap[1] = 0; gap[2] = 2;
        for (int i = 0; i < 3; i++) begin
            set_req[i] = 1'b0; set_hh[i] = '0; set_mm[i] = '0; set_ss[i] = '0;
            nld[i] = 0; nhold[i] = 0;
        end
        repeat (3) @(posedge clk);
        #2 check_zero("reset_outputs");
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Valid set at defaults, with busy/hold window checks.
        hb = nhold[0];
        @(posedge clk); #1;
        t0 = cyc;
        set_hh[0] = 6'd6; set_mm[0] = 6'd30; set_ss[0] = 6'd40; set_req[0] = 1'b1;
        push_seq(0, t0, 6'd6, 6'd30, 6'd40, 1'b1);
        @(posedge clk); #1 set_req[0] = 1'b0;
        set_hh[0] = 6'd1; set_mm[0] = 6'd2; set_ss[0] = 6'd3;
        wait_cyc(t0 + 10);
        @(negedge clk);
        chk("busy_low_cycle10", int'(busy[0]), 0);
        chk("hold_cycles", nhold[0] - hb, 8);
        wait_cyc(t0 + 12);

        // Range errors: no load, no hold.
        hb = nhold[0];
        req(0, 6'd24, 6'd0, 6'd0, 1'b0, 1, t0);
        req(0, 6'd0, 6'd60, 6'd0, 1'b0, 1, t0);
        req(0, 6'd0, 6'd0, 6'd63, 1'b0, 1, t0);
        chk("err_hold_cycles", nhold[0] - hb, 0);

        // Boundaries.
        req(0, 6'd23, 6'd59, 6'd59, 1'b1, 1, t0);
        req(2, 6'd23, 6'd59, 6'd59, 1'b0, 1, t0);
        req(2, 6'd11, 6'd59, 6'd59, 1'b1, 1, t0);

        // Request while busy, LOAD_GAP = 0: second request at cycle 3 is ignored.
        @(posedge clk); #1;
        t0 = cyc;
        set_hh[1] = 6'd12; set_mm[1] = 6'd34; set_ss[1] = 6'd56; set_req[1] = 1'b1;
        push_seq(1, t0, 6'd12, 6'd34, 6'd56, 1'b1);
        @(posedge clk); #1 set_req[1] = 1'b0;
        wait_cyc(t0 + 3);
        set_hh[1] = 6'd1; set_mm[1] = 6'd1; set_ss[1] = 6'd1; set_req[1] = 1'b1;
        @(posedge clk); #1 set_req[1] = 1'b0;
        wait_cyc(t0 + 12);
        chk("u1_load_count", nld[1], 3);

        // Asynchronous reset between hours and minutes writes.
        @(posedge clk); #1;
        t0 = cyc;
        set_hh[0] = 6'd7; set_mm[0] = 6'd8; set_ss[0] = 6'd9; set_req[0] = 1'b1;
        push(0, t0, 4'b1000, 2'b00, 6'd0, 1'b0, 1'b0, 1'b0);
        push(0, t0 + 2, 4'b0100, 2'b10, 6'd7, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1 set_req[0] = 1'b0;
        wait_cyc(t0 + 3);
        #1 reset = 1'b0;
        #1 check_zero("mid_reset_outputs");
        @(posedge clk); #1 reset = 1'b1;
        hb = nld[0];
        repeat (8) @(posedge clk);
        #1 chk("no_load_after_reset", nld[0] - hb, 0);
        req(0, 6'd9, 6'd15, 6'd0, 1'b1, 1, t0);

        // set_req held 20 cycles: two back-to-back sequences, no err.
        @(posedge clk); #1;
        t0 = cyc;
        set_hh[0] = 6'd20; set_mm[0] = 6'd45; set_ss[0] = 6'd5; set_req[0] = 1'b1;
        push_seq(0, t0, 6'd20, 6'd45, 6'd5, 1'b1);
        push_seq(0, t0 + 10, 6'd20, 6'd45, 6'd5, 1'b1);
        repeat (20) @(posedge clk);
        #1 set_req[0] = 1'b0;
        wait_cyc(t0 + 25);

        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/clk_time_set_ctrl.md
Name: clk_time_set_ctrl

Overview:
- Sequencer that programs the real-clock core's time registers through the core's load port (load / addrs / data_in).
- Accepts a full hh:mm:ss set request from a host (button FSM or UART decoder) and range-checks it.
- On a valid request, issues three single-cycle register writes in fixed order (hours, minutes, seconds) with a configurable gap between them.
- Asserts hold so the core does not advance mid-update; rejects out-of-range requests without writing anything.

Parameters:
- DW, 6, width of each time field and of the data bus to the core.
- LOAD_GAP, 2, idle cycles between consecutive writes; legal range 0..15, 0 = back-to-back writes.
- HR_MAX, 23, largest legal hours value (11 gives a 12-hour variant).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- set_req  in  1  level request; sampled only in IDLE.
- set_hh  in  DW  requested hours.
- set_mm  in  DW  requested minutes.
- set_ss  in  DW  requested seconds.
- set_ack  out  1  one-cycle pulse when a request is accepted.
- busy  out  1  high while a request is being processed.
- done  out  1  one-cycle pulse when all three writes have completed.
- err  out  1  one-cycle pulse when a request is rejected for range.
- hold  out  1  freeze for the core's counting, active during writes.
- load  out  1  write strobe to the clock core.
- addrs  out  2  register select: 00 = seconds, 01 = minutes, 10 = hours; 11 is never driven.
- data_out  out  DW  write data, connected to the core's data_in.

Behaviour:
- Reset (reset = 0, asynchronous): state goes to IDLE immediately; all outputs are 0, including addrs = 00 and data_out = 0.
- Reset mid-sequence: any remaining writes are abandoned and no partial-completion pulse is issued.
- States:
  - IDLE: if set_req = 1 at a clk edge, capture set_hh/set_mm/set_ss into internal registers, pulse set_ack, go to CHECK.
  - CHECK: valid when hh <= HR_MAX, mm <= 59 and ss <= 59 (unsigned compare on captured values). Valid goes to WR_HR; invalid goes to ERR.
  - ERR: err = 1 for one cycle, no write issued, then IDLE.
  - WR_HR: load = 1, addrs = 10, data_out = hh. Then GAP1 (or WR_MIN directly if LOAD_GAP = 0).
  - GAP1: LOAD_GAP cycles with load = 0, then WR_MIN.
  - WR_MIN: load = 1, addrs = 01, data_out = mm. Then GAP2 (or WR_SEC).
  - GAP2: LOAD_GAP cycles with load = 0, then WR_SEC.
  - WR_SEC: load = 1, addrs = 00, data_out = ss. Then DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- busy: 1 in every state except IDLE.
- hold: 1 from WR_HR through DONE inclusive; 0 in CHECK and ERR.
- load is high for exactly one cycle per write. In all non-write states, load = 0 and addrs/data_out hold their last value (0 after reset).
- Latency, with the acceptance edge as cycle 0: CHECK is cycle 1, first write is cycle 2, done is cycle 5 + 2*LOAD_GAP (cycle 9 at default), err is cycle 2.
- Inputs are captured once at acceptance; later changes to set_* do not affect the sequence in progress.
- set_req while busy is ignored (no queue).
- A set_req still high when the FSM returns to IDLE is accepted on that IDLE cycle's edge as a new request. The host must drop set_req after set_ack to avoid a repeat.
- The gap counter is 4 bits, loaded with LOAD_GAP on entry to each GAP state and decremented to 0. It has no wrap-around state.
- No arithmetic is performed on the time fields: values pass straight through, and range checks are compare-only.

Test Plan:
- Valid set, default parameters: after reset release, 06:30:40 with set_req held one cycle -> set_ack at cycle 0. Load pulses at cycles 2/5/8 with (addrs, data) = (10, 6), (01, 30), (00, 40). done at cycle 9; hold high over cycles 2-9; busy low at cycle 10.
- Range error: hh = 24, mm = 0, ss = 0 -> err pulse at cycle 2, load never asserted, hold stays 0. Repeat with mm = 60 and with ss = 63: same response.
- Boundary values: 23:59:59 is accepted and written. With HR_MAX = 11 the same request errors, while 11:59:59 is accepted.
- Request while busy, LOAD_GAP = 0: a second set_req at cycle 3 with different data is ignored. Writes occur at cycles 2/3/4 with the original data, done at cycle 5, and exactly three load pulses occur in total.
- Reset mid-operation: assert reset (0) asynchronously between the hours and minutes writes -> all outputs 0 within the same cycle. No further load after reset release; the next request starts from IDLE and completes normally.
- Held set_req: keep set_req high for 20 cycles -> two complete sequences. The second set_ack occurs on the edge after the first done; no err pulse.
